// File: rtl/wb_proj_driver_pkg.sv
// Shared definitions for the project driver: register map, CTRL/STATUS field
// positions and the step-engine state encoding.
package wb_proj_driver_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_STIM   = 3'd2;
    localparam logic [2:0] REG_RESP   = 3'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RUN     = 1;
    localparam int CTRL_SEL_LSB = 2;
    localparam int CTRL_DIV_LSB = 8;

    localparam int STAT_STIM_LSB = 0;
    localparam int STAT_RESP_LSB = 4;
    localparam int STAT_BUSY     = 8;
    localparam int STAT_OVF      = 9;
    localparam int STAT_UDF      = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        SAMPLE
    } step_state_t;

endpackage

// File: rtl/wb_proj_driver_sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Full/empty reflect the state
// before the current edge, so a simultaneous push and pop is always safe.
module sync_fifo
    import wb_proj_driver_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == DEPTH_L);
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_proj_driver.sv
// Wishbone-controlled step engine that drives a selected project's inputs one
// vector per generated clock and captures its outputs into a response FIFO.
module wb_proj_driver
    import wb_proj_driver_pkg::*;
#(
    parameter int SEL_BITS    = 3,
    parameter int INPUT_BITS  = 16,
    parameter int OUTPUT_BITS = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [5:0]             wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   drv_en,
    output logic [SEL_BITS-1:0]    drv_sel,
    output logic                   drv_clk,
    output logic                   drv_rst_n,
    output logic [INPUT_BITS-1:0]  drv_in,
    input  logic [OUTPUT_BITS-1:0] drv_out
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                   wb_req, wb_wr, wb_rd;
    logic [2:0]             reg_sel;
    logic [31:0]            rdata;
    logic                   ctrl_en, ctrl_run, ovf, udf;
    logic [SEL_BITS-1:0]    ctrl_sel;
    logic [15:0]            ctrl_div;

    logic                   stim_push, stim_pop, stim_full, stim_empty;
    logic [INPUT_BITS:0]    stim_data;
    logic [LVL_W-1:0]       stim_lvl;
    logic                   resp_push, resp_pop, resp_full, resp_empty;
    logic [OUTPUT_BITS-1:0] resp_data;
    logic [LVL_W-1:0]       resp_lvl;

    step_state_t            state, state_next;
    logic [15:0]            cnt, cnt_next;
    logic                   busy;
    logic                   unused_bits;

    assign wb_req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wb_wr       = wb_req & wbs_we_i;
    assign wb_rd       = wb_req & ~wbs_we_i;
    assign reg_sel     = wbs_adr_i[4:2];
    assign unused_bits = ^{wbs_adr_i[5], wbs_adr_i[1:0], wbs_dat_i};

    assign stim_push = wb_wr && (reg_sel == REG_STIM);
    assign resp_pop  = wb_rd && (reg_sel == REG_RESP) && !resp_empty;
    assign busy      = (state != IDLE);
    assign drv_clk   = (state == HIGH);
    assign drv_en    = ctrl_en;
    assign drv_sel   = ctrl_sel;

    sync_fifo #(.WIDTH(INPUT_BITS + 1), .DEPTH(FIFO_DEPTH)) u_stim_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .push      (stim_push),
        .push_data ({wbs_dat_i[31], wbs_dat_i[INPUT_BITS-1:0]}),
        .pop       (stim_pop),
        .pop_data  (stim_data),
        .full      (stim_full),
        .empty     (stim_empty),
        .level     (stim_lvl)
    );

    sync_fifo #(.WIDTH(OUTPUT_BITS), .DEPTH(FIFO_DEPTH)) u_resp_fifo (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .push      (resp_push),
        .push_data (drv_out),
        .pop       (resp_pop),
        .pop_data  (resp_data),
        .full      (resp_full),
        .empty     (resp_empty),
        .level     (resp_lvl)
    );

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata[CTRL_EN]                     = ctrl_en;
                rdata[CTRL_RUN]                    = ctrl_run;
                rdata[CTRL_SEL_LSB +: SEL_BITS]    = ctrl_sel;
                rdata[CTRL_DIV_LSB +: 16]          = ctrl_div;
            end
            REG_STATUS: begin
                rdata[STAT_STIM_LSB +: 4] = 4'(stim_lvl);
                rdata[STAT_RESP_LSB +: 4] = 4'(resp_lvl);
                rdata[STAT_BUSY]          = busy;
                rdata[STAT_OVF]           = ovf;
                rdata[STAT_UDF]           = udf;
            end
            REG_RESP: begin
                if (!resp_empty) rdata = 32'(resp_data);
            end
            default: rdata = '0;
        endcase
    end

    // All register side effects happen on the request cycle; ack and data follow one cycle later.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ctrl_en   <= 1'b0;
            ctrl_run  <= 1'b0;
            ctrl_sel  <= '0;
            ctrl_div  <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= wb_rd ? rdata : '0;
            if (wb_wr) begin
                case (reg_sel)
                    REG_CTRL: begin
                        ctrl_en  <= wbs_dat_i[CTRL_EN];
                        ctrl_run <= wbs_dat_i[CTRL_RUN];
                        ctrl_sel <= wbs_dat_i[CTRL_SEL_LSB +: SEL_BITS];
                        ctrl_div <= wbs_dat_i[CTRL_DIV_LSB +: 16];
                    end
                    REG_STATUS: begin
                        if (wbs_dat_i[STAT_OVF]) ovf <= 1'b0;
                        if (wbs_dat_i[STAT_UDF]) udf <= 1'b0;
                    end
                    REG_STIM: begin
                        if (stim_full) ovf <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (wb_rd && (reg_sel == REG_RESP) && resp_empty) udf <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Each phase lasts div+1 cycles; SAMPLE holds past zero while the response FIFO is full.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stim_pop   = 1'b0;
        resp_push  = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_run && !stim_empty) begin
                    stim_pop   = 1'b1;
                    state_next = SETUP;
                    cnt_next   = ctrl_div;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_next = HIGH;
                    cnt_next   = ctrl_div;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_next = SAMPLE;
                    cnt_next   = ctrl_div;
                end else begin
                    cnt_next = cnt - 16'd1;
                end
            end
            SAMPLE: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 16'd1;
                end else if (!resp_full) begin
                    resp_push  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            drv_in    <= '0;
            drv_rst_n <= 1'b1;
        end else if (stim_pop) begin
            drv_in    <= stim_data[INPUT_BITS-1:0];
            drv_rst_n <= ~stim_data[INPUT_BITS];
        end
    end

endmodule
